// File: rtl/pc_unit.sv
// Program-counter stage: holds the architectural PC, picks the next PC (seq/branch/JAL/JALR),
// sequences a boot cycle and traps on misaligned targets. Optional retire counter: PC_UNIT_INSTRET_EN.
module pc_unit #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            pc_src,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr
`ifdef PC_UNIT_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    // Without compressed instructions any target with bit 1 set is unreachable.
    function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
        return addr[1];
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] bad_addr_r;
    logic [XLEN-1:0] bad_addr_nxt_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] rel_sum_s;
    logic [XLEN-1:0] seq_s;
    logic [XLEN-1:0] target_s;
    logic            instr_valid_s;
    logic            misaligned_s;

    assign jalr_sum_s = rs1_data + imm;
    assign rel_sum_s  = pc_r + imm;
    assign seq_s      = pc_r + PC_STEP;

    // Target select: jalr beats jump beats taken branch beats sequential.
    always_comb begin
        target_s = seq_s;
        if (jalr) begin
            target_s = jalr_sum_s & JALR_MASK;
        end else if (jump) begin
            target_s = rel_sum_s;
        end else if (pc_src) begin
            target_s = rel_sum_s;
        end else begin
            target_s = seq_s;
        end
    end

    // Next-state logic: boot sequencing, stall hold, redirect or trap capture.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        bad_addr_nxt_s = bad_addr_r;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    state_nxt_s    = ST_RUN;
                    pc_nxt_s       = pc_r;
                    bad_addr_nxt_s = bad_addr_r;
                end else if (addr_misaligned(target_s)) begin
                    // pc keeps the faulting instruction's address for the handler.
                    state_nxt_s    = ST_TRAP;
                    pc_nxt_s       = pc_r;
                    bad_addr_nxt_s = target_s;
                end else begin
                    state_nxt_s    = ST_RUN;
                    pc_nxt_s       = target_s;
                    bad_addr_nxt_s = bad_addr_r;
                end
            end
            ST_TRAP: begin
                state_nxt_s = ST_TRAP;
            end
            default: begin
                // A corrupted state encoding is parked in TRAP until reset.
                state_nxt_s = ST_TRAP;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        instr_valid_s = 1'b0;
        misaligned_s  = 1'b0;
        case (state_r)
            ST_BOOT: begin
                instr_valid_s = 1'b0;
                misaligned_s  = 1'b0;
            end
            ST_RUN: begin
                instr_valid_s = ~stall;
                misaligned_s  = 1'b0;
            end
            ST_TRAP: begin
                instr_valid_s = 1'b0;
                misaligned_s  = 1'b1;
            end
            default: begin
                instr_valid_s = 1'b0;
                misaligned_s  = 1'b1;
            end
        endcase
    end

    // State, PC and trap-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_VECTOR;
            bad_addr_r <= {XLEN{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            bad_addr_r <= bad_addr_nxt_s;
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = seq_s;
    assign instr_valid = instr_valid_s;
    assign misaligned  = misaligned_s;
    assign bad_addr    = bad_addr_r;

`ifdef PC_UNIT_INSTRET_EN
    logic [63:0] instret_r;
    logic        retire_s;

    // An instruction retires when RUN advances the PC without stalling or trapping.
    always_comb begin
        retire_s = 1'b0;
        if ((state_r == ST_RUN) && !stall && !addr_misaligned(target_s)) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Retired-instruction counter, wraps silently at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= 64'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misaligned;
    logic [31:0] bad_addr;
`ifdef PC_UNIT_INSTRET_EN
    logic [63:0] instret;
`endif

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src), .jump(jump),
        .jalr(jalr), .imm(imm), .rs1_data(rs1_data), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .misaligned(misaligned), .bad_addr(bad_addr)
`ifdef PC_UNIT_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: 0 = boot, 1 = running, 2 = trapped
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_bad;
    logic [63:0] m_ret;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_target();
        if (jalr)             return (rs1_data + imm) & 32'hFFFF_FFFE;
        else if (jump || pc_src) return m_pc + imm;
        else                  return m_pc + 32'd4;
    endfunction

    task automatic check_all();
        chk("pc", {32'd0, pc}, {32'd0, m_pc});
        chk("pc_plus4", {32'd0, pc_plus4}, {32'd0, m_pc + 32'd4});
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, (m_state == 1) && !stall});
        chk("misaligned", {63'd0, misaligned}, {63'd0, m_state == 2});
        chk("bad_addr", {32'd0, bad_addr}, {32'd0, m_bad});
`ifdef PC_UNIT_INSTRET_EN
        chk("instret", instret, m_ret);
`endif
    endtask

    task automatic step(input logic st, input logic ps, input logic jm, input logic jr,
                        input logic [31:0] im, input logic [31:0] rs);
        logic [31:0] t;
        stall = st; pc_src = ps; jump = jm; jalr = jr; imm = im; rs1_data = rs;
        #1;
        check_all();
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && !st) begin
            t = m_target();
            if (t[1]) begin
                m_state = 2;
                m_bad   = t;
            end else begin
                m_pc  = t;
                m_ret = m_ret + 64'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [31:0] addr);
        step(1'b0, 1'b0, 1'b1, 1'b0, addr - m_pc, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_state = 0; m_pc = 32'd0; m_bad = 32'd0; m_ret = 64'd0;
        chk("async_rst_pc", {32'd0, pc}, 64'd0);
        chk("async_rst_misaligned", {63'd0, misaligned}, 64'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_state = 0; m_pc = 32'd0; m_bad = 32'd0; m_ret = 64'd0;
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // boot then sequential fetch
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("seq_pc12", {32'd0, pc}, 64'd12);

        goto(32'h100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0);
        chk("branch_taken", {32'd0, pc}, 64'hF0);
        goto(32'h100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0);
        chk("branch_not_taken", {32'd0, pc}, 64'h104);

        goto(32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'h1003);
        chk("jalr_trap_flag", {63'd0, misaligned}, 64'd1);
        chk("jalr_trap_addr", {32'd0, bad_addr}, 64'h1002);
        chk("jalr_trap_pc", {32'd0, pc}, 64'h200);
        for (int i = 0; i < 3; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        chk("trap_frozen_pc", {32'd0, pc}, 64'h200);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        goto(32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'h1001);
        chk("jalr_ok", {32'd0, pc}, 64'h1000);

        goto(32'h40);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
        chk("stall_hold_pc", {32'd0, pc}, 64'h40);
        chk("stall_no_trap", {63'd0, misaligned}, 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
        chk("unstall_trap_addr", {32'd0, bad_addr}, 64'h46);
        chk("unstall_trap_flag", {63'd0, misaligned}, 64'd1);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        goto(32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("pc_wrap", {32'd0, pc}, 64'd0);

        // retire count: 10 RUN cycles with 2 stalls, then a trap
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) step(i == 3 || i == 7, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
`ifdef PC_UNIT_INSTRET_EN
        chk("instret_8", instret, 64'd8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("instret_frozen", instret, 64'd8);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_state == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                logic [31:0] im;
                logic [31:0] rs;
                im = $urandom & 32'hFFFF_FFFC;
                rs = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 9) == 0) im = im | 32'd2;
                if ($urandom_range(0, 9) == 0) rs = rs | 32'd2;
                if ($urandom_range(0, 1) == 0) rs = rs | 32'd1;
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, im, rs);
            end
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle RISC-V core. It sits directly downstream of branch_unit and consumes its pc_src output.
- Holds the architectural PC and selects the next PC from: sequential, branch, JAL or JALR.
- Sequences a boot cycle after reset, honours a stall request, and traps on misaligned control-flow targets.
- Feeds instruction memory address, the pc+4 writeback path, and a valid flag to the decode/execute datapath.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and state this cycle.
- pc_src  input  1  branch-taken from branch_unit.
- jump  input  1  current instruction is JAL.
- jalr  input  1  current instruction is JALR.
- imm  input  XLEN  sign-extended immediate from the immediate generator.
- rs1_data  input  XLEN  register-file rs1 read data (JALR base).
- pc  output  XLEN  current PC / instruction-memory address.
- pc_plus4  output  XLEN  pc + 4, for JAL/JALR rd writeback.
- instr_valid  output  1  current pc holds a real instruction to execute.
- misaligned  output  1  sticky instruction-address-misaligned trap flag.
- bad_addr  output  XLEN  offending target address captured at trap.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_VECTOR, state=BOOT, instr_valid=0, misaligned=0, bad_addr=0.
- States: BOOT, RUN, TRAP. State is encoded in registers; outputs are decoded from state.
- BOOT:
  - instr_valid=0 and pc holds.
  - Next edge moves to RUN unconditionally; stall is ignored in BOOT.
  - pc_src, jump and jalr are ignored.
- RUN:
  - instr_valid = ~stall.
  - Target select, priority high to low:
    - jalr: (rs1_data + imm) & ~1.
    - jump: pc + imm.
    - pc_src: pc + imm.
    - otherwise: pc + 4.
  - Arithmetic is unsigned modulo 2^XLEN; wrap is silent (0xFFFF_FFFC + 4 = 0).
  - If stall=1: pc, state and bad_addr hold; no trap check is made.
  - Else if the selected target has target[1]=1 (misaligned; no compressed ISA):
    - Next edge: state=TRAP, misaligned=1, bad_addr=target.
    - pc holds the faulting instruction's address.
  - Else pc <= target on the next edge, giving a one-cycle redirect latency.
  - Sequential pc+4 can never misalign because pc is always aligned.
- TRAP:
  - pc frozen, instr_valid=0, misaligned=1, bad_addr frozen.
  - All inputs are ignored; the only exit is rst_n.
- pc_plus4 = pc + 4 combinationally in every state.
- Simultaneous jump and pc_src: jump wins. Simultaneous jalr and jump: jalr wins.
- Reset asserted mid-operation (any state): immediate return to reset values, independent of clk.

Optional Feature:
- Macro PC_UNIT_INSTRET_EN.
- When defined:
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 on each edge where state=RUN, stall=0 and no trap is taken.
  - Wraps at 2^64.
  - Holds in BOOT, TRAP and during stall.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then release, no control inputs: cycle 0 BOOT pc=0, instr_valid=0; then pc=0 valid, then 4, 8, 12 on successive edges.
- RUN at pc=0x100, pc_src=1, imm=0xFFFF_FFF0 -> pc=0xF0 next edge. Same with pc_src=0 -> 0x104. branch_unit's pc_src=0 when branch=0 must yield 0x104.
- pc=0x200, jalr=1, jump=1, pc_src=1, rs1_data=0x1003, imm=0 -> pc=0x1002? No: target 0x1002 has bit1=1 -> TRAP, misaligned=1, bad_addr=0x1002, pc stays 0x200. Rerun with rs1_data=0x1001 -> pc=0x1000.
- stall=1 for 3 cycles at pc=0x40 with pc_src=1, imm=0x6 -> pc holds 0x40, instr_valid=0, no trap. Then stall=0 -> trap with bad_addr=0x46.
- pc=0xFFFF_FFFC, no control -> pc wraps to 0. Assert rst_n=0 between clock edges while in TRAP -> pc=RESET_VECTOR and misaligned=0 immediately.
- With PC_UNIT_INSTRET_EN defined: 10 RUN cycles including 2 stalls, then a trap -> instret=8, frozen thereafter.
